// File: rtl/ps2_kbd_rx_pkg.sv
// Shared constants, receiver state type and frame check for the PS/2 keyboard receiver.
package ps2_kbd_rx_pkg;

  localparam int   PS2_FRAME_BITS         = 11;
  localparam logic PS2_START              = 1'b0;
  localparam logic PS2_STOP               = 1'b1;
  localparam int   DEFAULT_FIFO_DEPTH     = 8;
  localparam int   DEFAULT_TIMEOUT_CYCLES = 4096;

  typedef enum logic {
    S_IDLE,
    S_RECV
  } rx_state_t;

  // Frame is {stop, parity, d7..d0, start}; odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
    return (f[0] == PS2_START) && (f[PS2_FRAME_BITS-1] == PS2_STOP) && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_sync_fifo.sv
// Registered-array FIFO with wrap-bit pointers; a pop frees space for a push in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard frame receiver: oversampled pins, framing/parity check, idle timeout, byte FIFO.
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]    LAST_BIT   = 4'(PS2_FRAME_BITS - 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES - 1);

  logic [2:0]                clk_sync;
  logic [1:0]                data_sync;
  logic                      fall;
  rx_state_t                 state, state_d;
  logic [3:0]                bit_cnt, bit_cnt_d;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
  logic [IW-1:0]             idle_cnt, idle_cnt_d;
  logic                      err_d, push_d;
  logic                      push_q;
  logic [7:0]                push_byte_q;
  logic                      fifo_full, fifo_empty, pop_req;

  assign fall    = clk_sync[2] & ~clk_sync[1];
  assign ready   = ~fifo_empty;
  assign pop_req = ready & ~nextdata_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync    <= '0;
      data_sync   <= '0;
      state       <= S_IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      idle_cnt    <= '0;
      frame_err   <= 1'b0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      overflow    <= 1'b0;
    end else begin
      clk_sync    <= {clk_sync[1:0], ps2_clk};
      data_sync   <= {data_sync[0], ps2_data};
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      shift_q     <= shift_d;
      idle_cnt    <= idle_cnt_d;
      frame_err   <= err_d;
      push_q      <= push_d;
      push_byte_q <= shift_d[8:1];
      // A push into a full FIFO is only lost when no pop frees a slot this cycle.
      if (push_q && fifo_full && !pop_req) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift_q;
    idle_cnt_d = idle_cnt;
    err_d      = 1'b0;
    push_d     = 1'b0;
    if (fall) begin
      shift_d    = {data_sync[1], shift_q[PS2_FRAME_BITS-1:1]};
      idle_cnt_d = '0;
      if (bit_cnt == LAST_BIT) begin
        bit_cnt_d = '0;
        state_d   = S_IDLE;
        if (frame_ok(shift_d)) push_d = 1'b1;
        else                   err_d  = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt + 4'd1;
        state_d   = S_RECV;
      end
    end else if (state == S_RECV) begin
      // Keyboard stopped clocking mid-frame: abandon the partial frame.
      if (idle_cnt == IDLE_LIMIT) begin
        bit_cnt_d  = '0;
        idle_cnt_d = '0;
        state_d    = S_IDLE;
        err_d      = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt + 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_q),
    .pop  (pop_req),
    .wdata(push_byte_q),
    .rdata(data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: bit-level PS/2 driver, expected-byte queue, error-pulse monitor.
module tb_ps2_kbd_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       nextdata_n;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int n_checks   = 0;
  int n_pass     = 0;
  int err_cycles = 0;
  int err_before;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_kbd_rx dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .nextdata_n(nextdata_n),
    .data      (data),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always @(negedge clk) if (frame_err === 1'b1) err_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (30) tick();
    ps2_clk = 1'b0;
    repeat (30) tick();
    ps2_clk = 1'b1;
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] e;
    check({tag, "_ready"}, ready, 1);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: scoreboard empty, got data 0x%0h", tag, data);
    end else begin
      e = exp_q.pop_front();
      check(tag, data, e);
    end
    nextdata_n = 1'b0;
    tick();
    nextdata_n = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par);
    return {1'b1, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [10:0] f;
    f = make_frame(b, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
  endtask

  // Last bit is driven by hand so latency and a same-cycle pop can be placed exactly.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit chk_lat,
                            input bit pop_same);
    logic [10:0] f;
    f = make_frame(b, bad_par);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = f[10];
    repeat (30) tick();
    ps2_clk = 1'b0;
    repeat (3) tick();
    if (chk_lat) check("latency_3", ready, 0);
    if (pop_same) pop_one("pop_same_write");
    else tick();
    if (chk_lat) check("latency_4", ready, 1);
    repeat (26) tick();
    ps2_clk = 1'b1;
    repeat (30) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
  endtask

  initial begin
    rst        = 1'b1;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    nextdata_n = 1'b1;
    repeat (3) tick();
    check("rst_ready", ready, 0);
    check("rst_data", data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Good frame 0x1C with exact pin-to-ready latency.
    err_before = err_cycles;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    pop_one("t1_data");
    check("t1_ready_after_pop", ready, 0);
    check("t1_no_err", err_cycles - err_before, 0);

    // Parity error.
    err_before = err_cycles;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("t2_err_cycles", err_cycles - err_before, 1);
    check("t2_ready", ready, 0);
    check("t2_overflow", overflow, 0);

    // Overflow: ninth byte dropped.
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    end
    check("t3_no_overflow_yet", overflow, 0);
    send_frame(8'h09, 1'b0, 1'b0, 1'b0);
    check("t3_overflow", overflow, 1);
    check("t3_ready", ready, 1);
    for (int i = 0; i < 8; i++) pop_one("t3_pop");
    check("t3_empty", ready, 0);
    check("t3_overflow_sticky", overflow, 1);

    // Full FIFO plus simultaneous pop accepts the new byte.
    do_reset();
    check("t4_overflow_cleared", overflow, 0);
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    end
    exp_q.push_back(8'h0A);
    send_frame(8'h0A, 1'b0, 1'b0, 1'b1);
    check("t4_overflow", overflow, 0);
    for (int i = 0; i < 8; i++) pop_one("t4_pop");
    check("t4_empty", ready, 0);

    // Timeout on a partial frame, then a clean frame.
    err_before = err_cycles;
    send_partial(8'h00, 5);
    repeat (4200) tick();
    check("t5_timeout_err", err_cycles - err_before, 1);
    check("t5_ready", ready, 0);
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check("t5_no_extra_err", err_cycles - err_before, 1);
    pop_one("t5_data");

    // Asynchronous reset mid-frame with bytes queued.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'($urandom_range(0, 255)));
      send_frame(exp_q[exp_q.size() - 1], 1'b0, 1'b0, 1'b0);
    end
    check("t6_ready_before", ready, 1);
    send_partial(8'h33, 6);
    rst = 1'b1;
    #2;
    check("t6_ready_async", ready, 0);
    check("t6_overflow", overflow, 0);
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    pop_one("t6_data");
    check("t6_empty", ready, 0);
    check("t6_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
